adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_reader_pkg.sv | 15 +
 rtl/adc_sclk_gen.sv | 44 ++++
 rtl/adc_spi_reader.sv | 87 ++++++++
 tb/tb_adc_spi_reader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/adc_spi_reader_pkg.sv
// adc_spi_reader_pkg: state encoding, frame constants and address-bit helper
package adc_spi_reader_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;
  localparam int FRAME_BITS     = 16;
  localparam int ADDR_FIRST_BIT = 2;
  localparam int DATA_FIRST_BIT = 4;
  localparam int SAMPLE_W       = 12;
  localparam int CH_W           = 3;
  // channel address goes out MSB first on frame bits ADDR_FIRST_BIT..ADDR_FIRST_BIT+CH_W-1
  function automatic logic addr_bit(input logic [3:0] b, input logic [CH_W-1:0] ch);
    logic [3:0] k;
    k = b - 4'(ADDR_FIRST_BIT);
    return (k < 4'(CH_W)) ? ch[2'(CH_W - 1) - 2'(k)] : 1'b0;
  endfunction
endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: half-period timer for one 16-bit SCLK burst; sclk idles high
module adc_sclk_gen
  import adc_spi_reader_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       sclk,
  output logic       rise_en,
  output logic       fall_en,
  output logic       done,
  output logic [3:0] bit_idx
);
  logic       active_q, active_d, sclk_q, sclk_d, wrap;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] half_q, half_d;
  always_comb begin
    wrap     = active_q && cnt_q == 8'(CLK_DIV - 1);
    rise_en  = wrap && !half_q[0];
    done     = wrap && half_q == 5'(2 * FRAME_BITS - 1);
    fall_en  = start || (wrap && half_q[0] && !done);
    active_d = start || (active_q && !done);
    cnt_d    = (start || wrap) ? 8'd0 : active_q ? cnt_q + 8'd1 : cnt_q;
    half_d   = start ? 5'd0 : wrap ? half_q + 5'd1 : half_q;
    sclk_d   = fall_en ? 1'b0 : (rise_en || !active_d) ? 1'b1 : sclk_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b1;
      cnt_q    <= '0;
      half_q   <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
    end
  end
  assign sclk    = sclk_q;
  assign bit_idx = half_q[4:1];
endmodule

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: round-robin 12-bit SPI ADC scanner producing tagged sample strobes
module adc_spi_reader
  import adc_spi_reader_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NUM_CH  = 2,
  parameter int GAP     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic                adc_din,
  input  logic                adc_dout,
  output logic [SAMPLE_W-1:0] sample,
  output logic [CH_W-1:0]     sample_ch,
  output logic                sample_valid,
  output logic                busy
);
  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                s1_q, s2_q;
  logic [SAMPLE_W-1:0] sh_q, sh_d, sample_q, sample_d;
  logic [CH_W-1:0]     sample_ch_q, sample_ch_d, next_ch_q, next_ch_d, prev_ch_q, prev_ch_d;
  logic                valid_q, cs_n_q, cs_n_d, din_q, din_d, busy_q;
  logic                start, gap_end, rise_en, fall_en, done;
  logic [3:0]          bit_idx;
  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .rst_n(rst_n), .start(start), .sclk(adc_sclk),
    .rise_en(rise_en), .fall_en(fall_en), .done(done), .bit_idx(bit_idx)
  );
  // next_ch is the channel addressed in the current frame; the ADC converts it one frame later
  always_comb begin
    start       = state_q == S_SETUP && cnt_q == 16'(CLK_DIV - 1);
    gap_end     = state_q == S_GAP && cnt_q == 16'(GAP - 1);
    state_d     = state_q == S_IDLE ? (enable ? S_SETUP : S_IDLE)
                : start ? S_SHIFT : done ? S_GAP
                : gap_end ? (enable ? S_SETUP : S_IDLE) : state_q;
    cnt_d       = (state_d != state_q || state_q == S_IDLE || state_q == S_SHIFT) ? '0 : cnt_q + 16'd1;
    next_ch_d   = (state_d == S_SETUP && state_q != S_SETUP)
                ? (next_ch_q == CH_W'(NUM_CH - 1) ? '0 : next_ch_q + 1'b1) : next_ch_q;
    prev_ch_d   = done ? next_ch_q : prev_ch_q;
    sample_ch_d = done ? prev_ch_q : sample_ch_q;
    din_d       = fall_en ? addr_bit(start ? 4'd0 : bit_idx + 4'd1, next_ch_q) : din_q;
    sh_d        = rise_en ? {sh_q[SAMPLE_W-2:0], s2_q} : sh_q;
    sample_d    = done ? sh_q : sample_q;
    cs_n_d      = state_d == S_IDLE || state_d == S_GAP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      sh_q        <= '0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      next_ch_q   <= '0;
      prev_ch_q   <= '0;
      valid_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_q        <= adc_dout;
      s2_q        <= s1_q;
      sh_q        <= sh_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      next_ch_q   <= next_ch_d;
      prev_ch_q   <= prev_ch_d;
      valid_q     <= done;
      cs_n_q      <= cs_n_d;
      din_q       <= din_d;
      busy_q      <= !cs_n_d;
    end
  end
  assign adc_cs_n     = cs_n_q;
  assign adc_din      = din_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: directed checks of adc_spi_reader against a behavioral two-channel ADC
module tb_adc_spi_reader;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, adc_dout = 1'b0;
  logic        adc_cs_n, adc_sclk, adc_din, sample_valid, busy;
  logic [11:0] sample;
  logic [2:0]  sample_ch;
  int errors = 0, checks = 0;
  int cyc = 0, strobes = 0, busy_run = 0, last_run = 0, sclk_edges = 0;
  int t0 = 0, t1 = 0, snap_s = 0, snap_e = 0;
  logic [11:0] val [0:1];
  logic [3:0]  lead = 4'hA;
  logic [15:0] word = '0;
  int          fcnt = 0, rcnt = 0;
  logic [2:0]  addr = '0, conv_ch = '0, last_addr = '0;
  logic        sclk_p = 1'b1, cs_p = 1'b1;

  always #5 clk = ~clk;

  adc_spi_reader #(.CLK_DIV(4), .NUM_CH(2), .GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid), .busy(busy)
  );

  always @(posedge clk) begin
    cyc++;
    if (sample_valid) strobes++;
    if (!busy) busy_run++;
    else begin
      if (busy_run > 0) last_run = busy_run;
      busy_run = 0;
    end
  end

  always @(adc_sclk) sclk_edges++;

  // ADC: shifts {lead, value} out on SCLK falls, captures its address on rises, converts it next frame
  always @(adc_sclk or adc_cs_n or rst_n) begin
    if (!rst_n) begin
      conv_ch = '0;
      rcnt = 0;
    end
    if (cs_p && !adc_cs_n) begin
      fcnt = 0;
      rcnt = 0;
      word = {lead, val[conv_ch[0]]};
    end
    if (!adc_cs_n && sclk_p && !adc_sclk && fcnt < 16) begin
      adc_dout = word[4'(15 - fcnt)];
      fcnt++;
    end
    if (!adc_cs_n && !sclk_p && adc_sclk) begin
      if (rcnt >= 2 && rcnt <= 4) addr[2'(4 - rcnt)] = adc_din;
      rcnt++;
    end
    if (!cs_p && adc_cs_n && rcnt == 16) begin
      conv_ch = addr;
      last_addr = addr;
    end
    sclk_p = adc_sclk;
    cs_p = adc_cs_n;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 400);
    t = cyc;
    chk({tag, " strobe"}, 32'(sample_valid), 1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 100);
    chk({tag, " busy"}, 32'(busy), 1);
  endtask

  initial begin
    val[0] = 12'h123;
    val[1] = 12'hABC;
    repeat (3) @(negedge clk);
    chk("rst cs_n", 32'(adc_cs_n), 1);
    chk("rst sclk", 32'(adc_sclk), 1);
    chk("rst din", 32'(adc_din), 0);
    chk("rst sample", 32'(sample), 0);
    chk("rst ch", 32'(sample_ch), 0);
    chk("rst valid", 32'(sample_valid), 0);
    chk("rst busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle sclk", 32'(adc_sclk), 1);
    chk("idle busy", 32'(busy), 0);
    enable = 1'b1;
    wait_strobe("f1", t0);
    chk("f1 sample", 32'(sample), 'h123);
    chk("f1 ch", 32'(sample_ch), 0);
    chk("f1 addr", 32'(last_addr), 1);
    wait_strobe("f2", t1);
    chk("f2 sample", 32'(sample), 'hABC);
    chk("f2 ch", 32'(sample_ch), 1);
    chk("f2 addr", 32'(last_addr), 0);
    chk("f2 interval", t1 - t0, 136);
    repeat (10) @(negedge clk);
    chk("gap busy low", last_run, 4);
    wait_strobe("f3", t0);
    chk("f3 sample", 32'(sample), 'h123);
    chk("f3 ch", 32'(sample_ch), 0);
    chk("f3 interval", t0 - t1, 136);
    wait_busy("f4");
    repeat (68) @(negedge clk);
    chk("hold sample", 32'(sample), 'h123);
    chk("hold valid", 32'(sample_valid), 0);
    snap_s = strobes;
    enable = 1'b0;
    wait_strobe("drop", t1);
    chk("drop sample", 32'(sample), 'hABC);
    chk("drop ch", 32'(sample_ch), 1);
    @(negedge clk);
    chk("drop one strobe", strobes, snap_s + 1);
    snap_s = strobes;
    snap_e = sclk_edges;
    repeat (300) @(negedge clk);
    chk("idle no strobe", strobes, snap_s);
    chk("idle no sclk edge", sclk_edges, snap_e);
    chk("idle cs_n", 32'(adc_cs_n), 1);
    chk("idle busy low", 32'(busy), 0);
    enable = 1'b1;
    wait_busy("f5");
    repeat (84) @(negedge clk);
    snap_s = strobes;
    rst_n = 1'b0;
    #1;
    chk("midrst cs_n", 32'(adc_cs_n), 1);
    chk("midrst sclk", 32'(adc_sclk), 1);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst valid", 32'(sample_valid), 0);
    val[0] = 12'hFFF;
    val[1] = 12'h000;
    lead = 4'hB;
    repeat (3) @(negedge clk);
    chk("midrst no strobe", strobes, snap_s);
    chk("midrst sample", 32'(sample), 0);
    rst_n = 1'b1;
    wait_strobe("r1", t0);
    chk("r1 ch", 32'(sample_ch), 0);
    chk("r1 sample", 32'(sample), 'hFFF);
    chk("r1 addr", 32'(last_addr), 1);
    wait_strobe("r2", t1);
    chk("r2 ch", 32'(sample_ch), 1);
    chk("r2 sample", 32'(sample), 'h000);
    chk("r2 addr", 32'(last_addr), 0);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
